// File: rtl/func_sweep_ctrl.sv
// Self-test sequencer: sweeps every input vector of a small combinational block,
// waits SETTLE cycles, samples y and scores it against a golden truth table.
module func_sweep_ctrl #(
    parameter int N_IN = 3,
    parameter int SETTLE = 2,
    parameter logic [(2**N_IN)-1:0] EXPECTED = 8'h31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  y,
    output logic [N_IN-1:0]       abc,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [(2**N_IN)-1:0]  fail_mask,
    output logic [N_IN:0]         fail_count
);
    localparam int NV = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = '1;
    localparam logic [N_IN-1:0] ONE_IDX = 1;
    localparam logic [N_IN:0]   ONE_CNT = 1;
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [N_IN-1:0]   abc_q, abc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [NV-1:0]     fail_mask_q, fail_mask_d;
    logic [N_IN:0]     fail_count_q, fail_count_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        pass_d       = pass_q;
        fail_mask_d  = fail_mask_q;
        fail_count_d = fail_count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = APPLY;
                    idx_d        = '0;
                    cnt_d        = '0;
                    pass_d       = 1'b0;
                    fail_mask_d  = '0;
                    fail_count_d = '0;
                end
            end
            APPLY: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                // abort wins over the compare, so an aborted vector is never scored
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end else begin
                    if (y != EXPECTED[idx_q]) begin
                        fail_mask_d[idx_q] = 1'b1;
                        fail_count_d       = fail_count_q + ONE_CNT;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        idx_d   = '0;
                        cnt_d   = '0;
                        pass_d  = (fail_count_d == '0);
                    end else begin
                        state_d = APPLY;
                        idx_d   = idx_q + ONE_IDX;
                        cnt_d   = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        busy_d = (state_d == APPLY) || (state_d == SAMPLE);
        abc_d  = busy_d ? idx_d : '0;
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            abc_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_mask_q  <= '0;
            fail_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            abc_q        <= abc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_mask_q  <= fail_mask_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign abc        = abc_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_mask  = fail_mask_q;
    assign fail_count = fail_count_q;
endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Directed bench for func_sweep_ctrl: table of sweep scenarios on a SETTLE=2
// instance, plus reset-mid-sweep and a SETTLE=1 instance.
module tb_func_sweep_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, y;
    logic [2:0] abc;
    logic       busy, done, pass;
    logic [7:0] fail_mask;
    logic [3:0] fail_count;

    logic       start1;
    logic       y1;
    logic [2:0] abc1;
    logic       busy1, done1, pass1;
    logic [7:0] fail_mask1;
    logic [3:0] fail_count1;

    int tests = 0;
    int fails = 0;
    int ymode = 0;

    always #5 clk = ~clk;

    func_sweep_ctrl dut (
        .clk(clk), .reset(rst), .start(start), .abort(abort), .y(y),
        .abc(abc), .busy(busy), .done(done), .pass(pass),
        .fail_mask(fail_mask), .fail_count(fail_count)
    );

    func_sweep_ctrl #(.N_IN(3), .SETTLE(1), .EXPECTED(8'h31)) dut1 (
        .clk(clk), .reset(rst), .start(start1), .abort(1'b0), .y(y1),
        .abc(abc1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_mask(fail_mask1), .fail_count(fail_count1)
    );

    // Reference function: y=1 at abc = 000, 100, 101.
    function automatic logic sf(input logic [2:0] v);
        logic a, b, c;
        {a, b, c} = v;
        return (~a & ~b & ~c) | (a & ~b & ~c) | (a & ~b & c);
    endfunction

    always_comb begin
        case (ymode)
            0: y = sf(abc);
            1: y = 1'b0;
            2: y = 1'b1;
            3: y = ~sf(abc);
            default: y = abc[2];
        endcase
    end
    assign y1 = sf(abc1);

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Run one sweep on dut; k counts edges after the edge that sampled start.
    task automatic sweep(input int mode, input int restart_at, input int abort_at,
                         output int done_k, output int done_cnt,
                         output int abc_errs, output int busy_errs);
        bit aborted;
        int exp_abc;
        bit exp_busy;
        ymode = mode;
        done_k = -1; done_cnt = 0; abc_errs = 0; busy_errs = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            aborted  = (abort_at >= 0) && (k > abort_at);
            exp_busy = !aborted && (k < 24);
            exp_abc  = exp_busy ? k / 3 : 0;
            if (busy !== exp_busy) busy_errs++;
            if (k != 24 && abc !== 3'(exp_abc)) abc_errs++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            abort = (k == abort_at);
            start = (k == restart_at);
            @(posedge clk);
            #1;
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    typedef struct {
        string name;
        int    mode;
        int    restart_at;
        int    abort_at;
        int    exp_pass;
        int    exp_mask;
        int    exp_count;
        int    exp_dones;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int dk, dc, ae, be;
        vecs[0] = '{"correct",   0, -1, -1, 1, 8'h00, 0, 1};
        vecs[1] = '{"tie0",      1, -1, -1, 0, 8'h31, 3, 1};
        vecs[2] = '{"tie1",      2, -1, -1, 0, 8'hCE, 5, 1};
        vecs[3] = '{"inverted",  3, -1, -1, 0, 8'hFF, 8, 1};
        vecs[4] = '{"y_eq_a",    4, -1, -1, 0, 8'hC1, 3, 1};
        vecs[5] = '{"restart5",  0,  5, -1, 1, 8'h00, 0, 1};
        vecs[6] = '{"abort_s4",  1, -1, 14, 0, 8'h01, 1, 0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {abc, busy, done, pass, fail_mask, fail_count}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            sweep(vecs[i].mode, vecs[i].restart_at, vecs[i].abort_at, dk, dc, ae, be);
            check({vecs[i].name, "_pass"}, pass, vecs[i].exp_pass);
            check({vecs[i].name, "_mask"}, fail_mask, vecs[i].exp_mask);
            check({vecs[i].name, "_count"}, fail_count, vecs[i].exp_count);
            check({vecs[i].name, "_dones"}, dc, vecs[i].exp_dones);
            if (vecs[i].exp_dones == 1) check({vecs[i].name, "_done_cycle"}, dk, 24);
            check({vecs[i].name, "_abc_seq_errs"}, ae, 0);
            check({vecs[i].name, "_busy_errs"}, be, 0);
            $display("[TB] sweep %s: pass=%0d mask=0x%02h count=%0d dones=%0d done_k=%0d",
                     vecs[i].name, pass, fail_mask, fail_count, dc, dk);
        end

        // Asynchronous reset in the middle of vector 3 with partial failures recorded.
        ymode = 2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("pre_reset_state", {abc, busy, fail_mask, fail_count}, {3'd3, 1'b1, 8'h06, 4'd2});
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {abc, busy, done, pass, fail_mask, fail_count}, 0);
        $display("[TB] async reset mid-sweep: abc=%0d busy=%0b mask=0x%02h", abc, busy, fail_mask);
        @(negedge clk);
        rst = 1'b0;
        sweep(0, -1, -1, dk, dc, ae, be);
        check("post_reset_pass", pass, 1);
        check("post_reset_done_cycle", dk, 24);
        check("post_reset_abc_errs", ae, 0);
        $display("[TB] sweep after reset: pass=%0d done_k=%0d", pass, dk);

        // SETTLE=1 instance: each vector held two cycles, done after edge 16.
        begin
            int k1 = -1;
            int e1 = 0;
            @(negedge clk);
            start1 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (k < 16 && abc1 !== 3'(k / 2)) e1++;
                if (done1 === 1'b1 && k1 < 0) k1 = k;
                @(posedge clk);
                #1;
            end
            check("settle1_done_cycle", k1, 16);
            check("settle1_abc_errs", e1, 0);
            check("settle1_pass", pass1, 1);
            check("settle1_count", fail_count1, 0);
            $display("[TB] settle1 sweep: pass=%0d done_k=%0d abc_errs=%0d", pass1, k1, e1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
